mmu_xlate: RTL and testbench

MMU_XLATE -- requirements
Module: mmu_xlate

---
 rtl/mmu_xlate_pkg.sv | 31 +++
 rtl/mmu_xlate_if.sv | 30 +++
 rtl/mmu_xlate_dmw_match.sv | 27 ++
 rtl/mmu_xlate.sv | 152 +++++++++++++++
 tb/tb_mmu_xlate.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_xlate_pkg.sv
// Shared CPU definitions for address translation: exception codes,
// request type encodings and direct-map-window field positions.
package mmu_xlate_pkg;

  typedef enum logic [2:0] {
    ECODE_NONE = 3'd0,
    ECODE_TLBR = 3'd1,
    ECODE_PIL  = 3'd2,
    ECODE_PIS  = 3'd3,
    ECODE_PIF  = 3'd4,
    ECODE_PPI  = 3'd5,
    ECODE_PME  = 3'd6
  } ecode_e;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_type_e;

  // Direct map window register layout
  localparam int unsigned DMW_PLV0    = 0;
  localparam int unsigned DMW_PLV3    = 3;
  localparam int unsigned DMW_MAT_LO  = 4;
  localparam int unsigned DMW_MAT_HI  = 5;
  localparam int unsigned DMW_PSEG_LO = 25;
  localparam int unsigned DMW_PSEG_HI = 27;
  localparam int unsigned DMW_VSEG_LO = 29;
  localparam int unsigned DMW_VSEG_HI = 31;

endpackage

// File: rtl/mmu_xlate_if.sv
// Request/response handshake bundle between a requester and mmu_xlate.
interface mmu_xlate_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_va;
  logic [1:0]      req_type;
  logic [1:0]      req_plv;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_pa;
  logic [1:0]      rsp_mat;
  logic [2:0]      rsp_ecode;
  logic [IDXW-1:0] rsp_index;

  modport master (
    output req_valid, req_va, req_type, req_plv, rsp_ready,
    input  req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_ecode, rsp_index
  );

  modport slave (
    input  req_valid, req_va, req_type, req_plv, rsp_ready,
    output req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_ecode, rsp_index
  );

endinterface

// File: rtl/mmu_xlate_dmw_match.sv
// Match one direct map window against a virtual address and privilege level.
module dmw_match
  import mmu_xlate_pkg::*;
(
  input  logic [31:0] dmw_i,
  input  logic [31:0] va_i,
  input  logic [1:0]  plv_i,
  output logic        hit_o,
  output logic [31:0] pa_o,
  output logic [1:0]  mat_o
);

  logic plv_en;
  logic unused_dmw;

  // Only PLV0 and PLV3 have window enables; PLV1/2 never hit.
  always_comb begin
    plv_en = ((plv_i == 2'd0) && dmw_i[DMW_PLV0]) ||
             ((plv_i == 2'd3) && dmw_i[DMW_PLV3]);
    hit_o  = plv_en && (va_i[31:29] == dmw_i[DMW_VSEG_HI:DMW_VSEG_LO]);
    pa_o   = {dmw_i[DMW_PSEG_HI:DMW_PSEG_LO], va_i[28:0]};
    mat_o  = dmw_i[DMW_MAT_HI:DMW_MAT_LO];
  end

  assign unused_dmw = ^{dmw_i[28], dmw_i[24:6], dmw_i[2:1]};

endmodule

// File: rtl/mmu_xlate.sv
// Two-stage virtual-to-physical translation pipeline: S1 holds the request
// and drives the external TLB search port, S2 holds the registered result.
module mmu_xlate
  import mmu_xlate_pkg::*;
#(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             resetn,
  mmu_xlate_if.slave       bus,
  input  logic             flush,
  input  logic             crmd_da,
  input  logic             crmd_pg,
  input  logic [1:0]       crmd_datm,
  input  logic [31:0]      dmw0,
  input  logic [31:0]      dmw1,
  input  logic [9:0]       csr_asid,
  output logic [18:0]      s_vppn,
  output logic             s_va_bit12,
  output logic [9:0]       s_asid,
  input  logic             s_found,
  input  logic [IDXW-1:0]  s_index,
  input  logic [19:0]      s_ppn,
  input  logic [5:0]       s_ps,
  input  logic [1:0]       s_plv,
  input  logic [1:0]       s_mat,
  input  logic             s_d,
  input  logic             s_v
);

  logic            s1_valid_q;
  logic [31:0]     s1_va_q;
  req_type_e       s1_type_q;
  logic [1:0]      s1_plv_q;

  logic            s2_valid_q;
  logic [31:0]     s2_pa_q,    pa_d;
  logic [1:0]      s2_mat_q,   mat_d;
  ecode_e          s2_ecode_q, ecode_d;
  logic [IDXW-1:0] s2_index_q, index_d;

  logic            s1_adv, s2_adv;
  logic            hit0, hit1;
  logic [31:0]     pa0, pa1;
  logic [1:0]      mat0, mat1;
  logic            unused_pg;

  // Direct mode is selected by da alone; pg carries no extra information here.
  assign unused_pg = crmd_pg;

  assign s2_adv = !s2_valid_q || bus.rsp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Flush always empties the pipe, so the request side never looks blocked.
  assign bus.req_ready = s1_adv || flush;

  assign s_vppn     = s1_va_q[31:13];
  assign s_va_bit12 = s1_va_q[12];
  assign s_asid     = csr_asid;

  dmw_match u_dmw0 (
    .dmw_i (dmw0), .va_i (s1_va_q), .plv_i (s1_plv_q),
    .hit_o (hit0), .pa_o (pa0),     .mat_o (mat0)
  );

  dmw_match u_dmw1 (
    .dmw_i (dmw1), .va_i (s1_va_q), .plv_i (s1_plv_q),
    .hit_o (hit1), .pa_o (pa1),     .mat_o (mat1)
  );

  // Translation of the S1 request: direct, then DMW0, DMW1, then TLB.
  always_comb begin
    pa_d    = s1_va_q;
    mat_d   = crmd_datm;
    ecode_d = ECODE_NONE;
    index_d = '0;
    if (crmd_da) begin
      pa_d  = s1_va_q;
      mat_d = crmd_datm;
    end else if (hit0) begin
      pa_d  = pa0;
      mat_d = mat0;
    end else if (hit1) begin
      pa_d  = pa1;
      mat_d = mat1;
    end else begin
      index_d = s_index;
      mat_d   = s_mat;
      pa_d    = (s_ps == 6'd21) ? {s_ppn[19:9], s1_va_q[20:0]}
                                : {s_ppn, s1_va_q[11:0]};
      if (!s_found) begin
        ecode_d = ECODE_TLBR;
      end else if (!s_v) begin
        case (s1_type_q)
          REQ_FETCH: ecode_d = ECODE_PIF;
          REQ_STORE: ecode_d = ECODE_PIS;
          default:   ecode_d = ECODE_PIL;
        endcase
      end else if (s1_plv_q > s_plv) begin
        ecode_d = ECODE_PPI;
      end else if ((s1_type_q == REQ_STORE) && !s_d) begin
        ecode_d = ECODE_PME;
      end
    end
  end

  // S1 register: accepts a new request whenever it can advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_va_q    <= '0;
      s1_type_q  <= REQ_FETCH;
      s1_plv_q   <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.req_valid;
      s1_va_q    <= bus.req_va;
      s1_type_q  <= req_type_e'(bus.req_type);
      s1_plv_q   <= bus.req_plv;
    end
  end

  // S2 register: result fields are held unless a valid S1 entry moves in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_pa_q    <= '0;
      s2_mat_q   <= '0;
      s2_ecode_q <= ECODE_NONE;
      s2_index_q <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_pa_q    <= pa_d;
        s2_mat_q   <= mat_d;
        s2_ecode_q <= ecode_d;
        s2_index_q <= index_d;
      end
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_pa    = s2_pa_q;
  assign bus.rsp_mat   = s2_mat_q;
  assign bus.rsp_ecode = s2_ecode_q;
  assign bus.rsp_index = s2_index_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Self-checking bench for mmu_xlate with a scoreboard of expected responses.
module tb_mmu_xlate;
  import mmu_xlate_pkg::*;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = $clog2(TLBNUM);

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            flush = 1'b0;
  logic            crmd_da, crmd_pg;
  logic [1:0]      crmd_datm;
  logic [31:0]     dmw0, dmw1;
  logic [9:0]      csr_asid;
  logic [18:0]     s_vppn;
  logic            s_va_bit12;
  logic [9:0]      s_asid;

  logic            st_found, st_d, st_v;
  logic [IDXW-1:0] st_index;
  logic [19:0]     st_ppn;
  logic [5:0]      st_ps;
  logic [1:0]      st_plv, st_mat;

  mmu_xlate_if #(.TLBNUM(TLBNUM)) bus ();

  mmu_xlate #(.TLBNUM(TLBNUM)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .flush      (flush),
    .crmd_da    (crmd_da),
    .crmd_pg    (crmd_pg),
    .crmd_datm  (crmd_datm),
    .dmw0       (dmw0),
    .dmw1       (dmw1),
    .csr_asid   (csr_asid),
    .s_vppn     (s_vppn),
    .s_va_bit12 (s_va_bit12),
    .s_asid     (s_asid),
    .s_found    (st_found),
    .s_index    (st_index),
    .s_ppn      (st_ppn),
    .s_ps       (st_ps),
    .s_plv      (st_plv),
    .s_mat      (st_mat),
    .s_d        (st_d),
    .s_v        (st_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     pa;
    logic [1:0]      mat;
    logic [2:0]      ecode;
    logic [IDXW-1:0] idx;
    bit              chk_idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference translation computed from the bench's own copies of the CSRs/TLB stub.
  function automatic exp_t model(input logic [31:0] va, input logic [1:0] typ,
                                 input logic [1:0] plv);
    exp_t        e;
    logic [31:0] w;
    bit          en;
    e.pa = 32'h0; e.mat = 2'd0; e.ecode = 3'd0; e.idx = '0; e.chk_idx = 1'b0;
    if (crmd_da) begin
      e.pa  = va;
      e.mat = crmd_datm;
      return e;
    end
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? dmw0 : dmw1;
      en = ((plv == 2'd0) && w[0]) || ((plv == 2'd3) && w[3]);
      if (en && (w[31:29] == va[31:29])) begin
        e.pa  = {w[27:25], va[28:0]};
        e.mat = w[5:4];
        return e;
      end
    end
    e.mat = st_mat;
    if (st_ps == 6'd21) e.pa = {st_ppn[19:9], va[20:0]};
    else                e.pa = {st_ppn, va[11:0]};
    if (!st_found) begin
      e.ecode = 3'd1;
    end else begin
      e.chk_idx = 1'b1;
      e.idx     = st_index;
      if (!st_v)                         e.ecode = (typ == 2'd0) ? 3'd4 : (typ == 2'd2) ? 3'd3 : 3'd2;
      else if (plv > st_plv)             e.ecode = 3'd5;
      else if ((typ == 2'd2) && !st_d)   e.ecode = 3'd6;
    end
    return e;
  endfunction

  task automatic stub(input logic found, input logic [5:0] ps, input logic [19:0] ppn,
                      input logic v, input logic d, input logic [1:0] plv,
                      input logic [IDXW-1:0] idx, input logic [1:0] mat);
    st_found = found; st_ps = ps; st_ppn = ppn; st_v = v; st_d = d;
    st_plv = plv; st_index = idx; st_mat = mat;
  endtask

  // Present one request (called just after a rising edge); returns just after
  // the edge that accepted it.
  task automatic send(input logic [31:0] va, input logic [1:0] typ, input logic [1:0] plv);
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_va = va; bus.req_type = typ; bus.req_plv = plv;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) chk("send_timeout", 32'd0, 32'd1);
    else begin
      sb.push_back(model(va, typ, plv));
      n_acc++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (resetn && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("stale_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_ecode", 32'(bus.rsp_ecode), 32'(mon_e.ecode));
        if (mon_e.ecode == 3'd0) begin
          chk("rsp_pa",  bus.rsp_pa, mon_e.pa);
          chk("rsp_mat", 32'(bus.rsp_mat), 32'(mon_e.mat));
        end
        if (mon_e.chk_idx) chk("rsp_index", 32'(bus.rsp_index), 32'(mon_e.idx));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] snap_pa;
    logic [2:0]  snap_ec;
    logic [1:0]  snap_mat;
    int          acc0, c0;

    bus.req_valid = 1'b0; bus.req_va = '0; bus.req_type = '0; bus.req_plv = '0;
    bus.rsp_ready = 1'b1;
    crmd_da = 1'b1; crmd_pg = 1'b0; crmd_datm = 2'd1;
    dmw0 = '0; dmw1 = '0; csr_asid = 10'h02A;
    stub(1'b1, 6'd12, 20'h12345, 1'b1, 1'b0, 2'd3, 4'd5, 2'd2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_pa",    bus.rsp_pa, 32'd0);
    chk("rst_rsp_mat",   32'(bus.rsp_mat), 32'd0);
    chk("rst_rsp_ecode", 32'(bus.rsp_ecode), 32'd0);
    chk("rst_rsp_index", 32'(bus.rsp_index), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Direct mode with two-cycle latency
    send(32'h1C00_0123, 2'd1, 2'd0);
    @(negedge clk);
    chk("lat_cycle1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(bus.rsp_valid), 32'd1);
    chk("da_pa",  bus.rsp_pa, 32'h1C00_0123);
    chk("da_mat", 32'(bus.rsp_mat), 32'd1);
    wait_drain();

    // Throughput: four back-to-back requests in four cycles
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(32'h1C00_0000 + 32'(i * 4), 2'd1, 2'd0);
    chk("throughput", 32'(cyc - c0), 32'd4);
    wait_drain();

    // DMW0 hit at PLV0, TLB path for the same address at PLV3
    crmd_da = 1'b0; crmd_pg = 1'b1; dmw0 = 32'hA000_0011;
    send(32'hA000_4000, 2'd1, 2'd0);
    send(32'hA000_4000, 2'd1, 2'd3);
    wait_drain();

    // DMW1 hit, and DMW0 priority when both windows match
    dmw1 = 32'h8200_0009;
    send(32'h8000_1234, 2'd1, 2'd3);
    dmw0 = 32'h8000_0031;
    wait_drain();
    send(32'h8000_1234, 2'd2, 2'd0);
    wait_drain();

    // TLB translation: load OK, store to clean page -> PME
    dmw0 = '0; dmw1 = '0;
    send(32'h0040_1ABC, 2'd1, 2'd0);
    chk("s_vppn",     32'(s_vppn), 32'h200);
    chk("s_va_bit12", 32'(s_va_bit12), 32'd1);
    chk("s_asid",     32'(s_asid), 32'h02A);
    send(32'h0040_1ABC, 2'd2, 2'd0);
    wait_drain();

    // TLB miss
    stub(1'b0, 6'd12, 20'h12345, 1'b1, 1'b0, 2'd3, 4'd7, 2'd2);
    send(32'h0040_1ABC, 2'd1, 2'd0);
    wait_drain();

    // Invalid entry per access type
    stub(1'b1, 6'd12, 20'h12345, 1'b0, 1'b1, 2'd3, 4'd9, 2'd2);
    send(32'h0040_1ABC, 2'd0, 2'd0);
    send(32'h0040_1ABC, 2'd1, 2'd0);
    send(32'h0040_1ABC, 2'd2, 2'd0);
    wait_drain();

    // Privilege violation
    stub(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd0, 4'd3, 2'd1);
    send(32'h0040_1ABC, 2'd1, 2'd3);
    wait_drain();

    // Large page
    stub(1'b1, 6'd21, 20'h12345, 1'b1, 1'b1, 2'd3, 4'd12, 2'd0);
    send(32'h0040_1ABC, 2'd2, 2'd3);
    wait_drain();

    // Backpressure: four requests, rsp_ready low for three stalled cycles
    stub(1'b1, 6'd12, 20'h12345, 1'b1, 1'b1, 2'd3, 4'd5, 2'd2);
    bus.rsp_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h0040_1000 + 32'(i * 32'h111), 2'd1, 2'd0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_accepted", 32'(n_acc - acc0), 32'd2);
        chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        snap_pa = bus.rsp_pa; snap_ec = bus.rsp_ecode; snap_mat = bus.rsp_mat;
        repeat (2) begin
          @(negedge clk);
          chk("stall_pa",    bus.rsp_pa, snap_pa);
          chk("stall_ecode", 32'(bus.rsp_ecode), 32'(snap_ec));
          chk("stall_mat",   32'(bus.rsp_mat), 32'(snap_mat));
          chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with both stages full; the request presented during flush is dropped
    bus.rsp_ready = 1'b0;
    send(32'h0040_2000, 2'd1, 2'd0);
    send(32'h0040_3000, 2'd1, 2'd0);
    flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_va = 32'h0040_4000; bus.req_type = 2'd1; bus.req_plv = 2'd0;
    @(negedge clk);
    chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; bus.req_valid = 1'b0;
    sb.delete();
    bus.rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("flush_quiet", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Reset pulsed with both stages full
    bus.rsp_ready = 1'b0;
    send(32'h0040_5000, 2'd1, 2'd0);
    send(32'h0040_6000, 2'd1, 2'd0);
    resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_pa",    bus.rsp_pa, 32'd0);
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random mix of paths with random backpressure
    dmw0 = 32'hA000_0011; dmw1 = 32'h8200_0009;
    stub(1'b1, 6'd12, 20'hABCDE, 1'b1, 1'b0, 2'd3, 4'd11, 2'd1);
    fork
      begin
        logic [31:0] va;
        logic [1:0]  typ, plv;
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 2))
            0:       va = 32'hA000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
            1:       va = 32'h8000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
            default: va = 32'h0040_0000 | 32'($urandom_range(0, 32'h000F_FFFF));
          endcase
          typ = 2'($urandom_range(0, 2));
          plv = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
          send(va, typ, plv);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 1) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
